sort_gate_sequencer: RTL



---
 rtl/sort_pkg.sv | 26 ++
 rtl/input_debounce.sv | 59 +++++
 rtl/sort_gate_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package    : sort_pkg                                            |
// | Description: Shared types, constants and helpers for the colour  |
// |              sort gate sequencer.                                |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package sort_pkg;

   // Sequencer states: waiting for an item, gate open, retract gap.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPEN = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Class value meaning "no gate" (item passes straight through).
   localparam int CLASS_OTHER = 0;

   // One bit of the one-hot gate vector: class k drives gate k-1.
   function automatic logic class_selects_gate(input int cls, input int gate_idx);
      return (cls != CLASS_OTHER) && (cls == gate_idx + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : input_debounce                                      |
// | Description: 2-flop synchroniser, stability filter and one-cycle |
// |              pulse on each filtered high-to-low transition.      |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module input_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic fall_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             fall_q, fall_d;

   // Count consecutive cycles the synchronised input disagrees with the
   // filtered level; accept the new level once the count completes.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      fall_d  = 1'b0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and filter registers; idle level is high (no object).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], async_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/sort_gate_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : sort_gate_sequencer                                 |
// | Description: Queues colour classes captured on IR detect events  |
// |              and opens one servo gate per item for a fixed hold  |
// |              time followed by a closed retract gap.              |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module sort_gate_sequencer
   import sort_pkg::*;
#(
   parameter int NUM_GATES       = 2,
   parameter int CLASS_W         = 2,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int GAP_CYCLES      = 5000000,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int DEPTH           = 4
) (
   input  logic                       mclk,
   input  logic                       rst,
   input  logic                       detecto,
   input  logic                       class_valid,
   input  logic [CLASS_W-1:0]         class_id,
   input  logic                       clear_overflow,
   output logic [NUM_GATES-1:0]       gate_sel,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     queue_level,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LW      = AW + 1;
   localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

   logic                 detect_evt;
   logic [CLASS_W-1:0]   cls_in;
   logic [CLASS_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]        level_q;
   logic                 fifo_empty, fifo_full, push, pop, drop;
   logic [NUM_GATES-1:0] head_onehot;
   state_e               state_q, state_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [NUM_GATES-1:0] gate_q, gate_d;
   logic                 overflow_q;
   logic [7:0]           drop_cnt_q;

   input_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i   (mclk),
      .rst_i   (rst),
      .async_i (detecto),
      .fall_o  (detect_evt)
   );

   // Class to store: invalid or out-of-range classes become pass-through.
   always_comb begin
      cls_in = class_valid ? class_id : CLASS_W'(CLASS_OTHER);
      if (cls_in > CLASS_W'(NUM_GATES)) begin
         cls_in = CLASS_W'(CLASS_OTHER);
      end
   end

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LW'(DEPTH));
   // A full queue still accepts an item if the head leaves the same cycle.
   assign push       = detect_evt & (~fifo_full | pop);
   assign drop       = detect_evt & fifo_full & ~pop;

   // Gate pattern for the item at the head of the queue.
   always_comb begin
      head_onehot = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         head_onehot[g] = class_selects_gate(int'(mem_q[rd_ptr_q]), g);
      end
   end

   // Queue storage; contents need no reset since occupancy is tracked.
   always_ff @(posedge mclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= cls_in;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge mclk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   // Sequencer next state: open for the hold time, close for the gap,
   // and chain straight into the next item when one is waiting.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      gate_d  = gate_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_OPEN;
               timer_d = HOLD_LAST;
               gate_d  = head_onehot;
            end
         end
         ST_OPEN: begin
            if (timer_q == '0) begin
               state_d = ST_GAP;
               timer_d = GAP_LAST;
               gate_d  = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (timer_q == '0) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_OPEN;
                  timer_d = HOLD_LAST;
                  gate_d  = head_onehot;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
            gate_d  = '0;
         end
      endcase
   end

   // Sequencer registers; reset closes every gate on the next edge.
   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         gate_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         gate_q  <= gate_d;
      end
   end

   // Sticky overflow flag and saturating drop counter; clear wins.
   always_ff @(posedge mclk) begin
      if (rst || clear_overflow) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign gate_sel    = gate_q;
   assign busy        = (state_q != ST_IDLE);
   assign queue_level = level_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_cnt_q;

endmodule
`default_nettype wire
